// File: rtl/cpu_boot_loader.sv
// Boot loader feeding the cpu top level: parses a 64-bit command stream,
// writes payload words into instruction/data memory, then runs the cpu for
// a cycle budget or until a STOP word arrives.
module cpu_boot_loader #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic [63:0]      wdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_count
);

    // state     | meaning
    // ST_IDLE   | waiting for a header word
    // ST_LOAD_I | consuming payload words into instruction memory
    // ST_LOAD_D | consuming payload words into data memory
    // ST_RUN    | cpu enabled, counting cycles until budget or STOP
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_I = 2'd1;
    localparam logic [1:0] ST_LOAD_D = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [1:0] CMD_LOAD_I = 2'b00;
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;
    localparam logic [1:0] CMD_STOP   = 2'b11;

    localparam logic [IMEM_ADDR_W-1:0] I_ONE   = 1;
    localparam logic [DMEM_ADDR_W-1:0] D_ONE   = 1;
    localparam logic [CNT_W-1:0]       CNT_ONE = 1;

    logic [1:0]             state;
    logic [IMEM_ADDR_W-1:0] widx_i;
    logic [DMEM_ADDR_W-1:0] widx_d;
    logic [15:0]            remaining;
    logic                   wrapped;
    // Down-counter for the run budget; zero means unlimited, since a
    // limited run exits when it reaches one and never gets to zero.
    logic [CNT_W-1:0]       run_left;
    logic [1:0]             cmd;

    assign cmd     = s_data[63:62];
    assign s_ready = 1'b1;
    assign busy    = (state != ST_IDLE);

    // Command decode, memory write registers and run control.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= ST_IDLE;
            widx_i      <= '0;
            widx_d      <= '0;
            remaining   <= '0;
            wrapped     <= 1'b0;
            run_left    <= '0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        case (cmd)
                            CMD_LOAD_I: begin
                                if (s_data[15:0] != 16'd0) begin
                                    state     <= ST_LOAD_I;
                                    widx_i    <= s_data[32 +: IMEM_ADDR_W];
                                    remaining <= s_data[15:0];
                                    wrapped   <= 1'b0;
                                end
                            end
                            CMD_LOAD_D: begin
                                if (s_data[15:0] != 16'd0) begin
                                    state     <= ST_LOAD_D;
                                    widx_d    <= s_data[32 +: DMEM_ADDR_W];
                                    remaining <= s_data[15:0];
                                    wrapped   <= 1'b0;
                                end
                            end
                            CMD_RUN: begin
                                state       <= ST_RUN;
                                cpu_enable  <= 1'b1;
                                cycle_count <= '0;
                                done        <= 1'b0;
                                run_left    <= s_data[CNT_W-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD_I: begin
                    if (s_valid) begin
                        wen_ext   <= 1'b1;
                        addr_ext  <= {{(62-IMEM_ADDR_W){1'b0}}, widx_i, 2'b00};
                        wdata_ext <= s_data[31:0];
                        widx_i    <= widx_i + I_ONE;
                        if (&widx_i) wrapped <= 1'b1;
                        if (wrapped) err <= 1'b1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= ST_IDLE;
                    end
                end
                ST_LOAD_D: begin
                    if (s_valid) begin
                        wen_ext_2   <= 1'b1;
                        addr_ext_2  <= {{(61-DMEM_ADDR_W){1'b0}}, widx_d, 3'b000};
                        wdata_ext_2 <= s_data;
                        widx_d      <= widx_d + D_ONE;
                        if (&widx_d) wrapped <= 1'b1;
                        if (wrapped) err <= 1'b1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= ST_IDLE;
                    end
                end
                default: begin
                    if (~&cycle_count) cycle_count <= cycle_count + CNT_ONE;
                    if (run_left != '0) run_left <= run_left - CNT_ONE;
                    // Budget expiry and STOP may coincide; both take the same exit.
                    if ((s_valid && cmd == CMD_STOP) || run_left == CNT_ONE) begin
                        state      <= ST_IDLE;
                        cpu_enable <= 1'b0;
                        done       <= 1'b1;
                    end
                    if (s_valid && cmd != CMD_STOP) err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Self-checking bench for cpu_boot_loader with a transaction-level model.
module tb_cpu_boot_loader;
    localparam int IW = 9;
    localparam int DW = 10;
    localparam int CW = 32;

    logic          clk, arst, s_valid, s_ready;
    logic [63:0]   s_data;
    logic [63:0]   addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0]   wdata_ext;
    logic          wen_ext, wen_ext_2, cpu_enable, busy, done, err;
    logic [CW-1:0] cycle_count;

    cpu_boot_loader #(.IMEM_ADDR_W(IW), .DMEM_ADDR_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .arst(arst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit      m_err  = 1'b0;
    bit      m_done = 1'b0;
    longint  m_cnt  = 0;

    // one cycle of stimulus; outputs are stable when this returns
    task automatic drive(input logic v, input logic [63:0] d);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_load(input bit is_d, input int base, input int n, input int gapmax);
        logic [63:0] hdr, pay, ea;
        int w, bt, idx, gaps;
        hdr = {(is_d ? 2'b01 : 2'b00), 14'd0, base[15:0], 16'd0, n[15:0]};
        drive(1'b1, hdr);
        n_cmp++;
        if (busy !== (n != 0) || wen_ext !== 1'b0 || wen_ext_2 !== 1'b0) begin
            n_bad++;
            $display("FAIL load_hdr busy=%b wen=%b/%b expected busy=%b wen=0/0", busy, wen_ext, wen_ext_2, n != 0);
        end
        w  = is_d ? DW : IW;
        bt = base % (1 << w);
        for (int k = 0; k < n; k++) begin
            gaps = $urandom_range(0, gapmax);
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, {$urandom, $urandom});
                n_cmp++;
                if (wen_ext !== 1'b0 || wen_ext_2 !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL load_gap wen=%b/%b busy=%b expected 0/0 busy=1", wen_ext, wen_ext_2, busy);
                end
            end
            pay = {$urandom, $urandom};
            drive(1'b1, pay);
            idx = bt + k;
            if (idx >= (1 << w)) m_err = 1'b1;
            ea = 64'(idx % (1 << w)) * (is_d ? 64'd8 : 64'd4);
            n_cmp++;
            if (is_d) begin
                if (wen_ext_2 !== 1'b1 || wen_ext !== 1'b0 || addr_ext_2 !== ea || wdata_ext_2 !== pay) begin
                    n_bad++;
                    $display("FAIL load_d_write k=%0d got wen=%b/%b addr=%h data=%h expected wen=0/1 addr=%h data=%h",
                             k, wen_ext, wen_ext_2, addr_ext_2, wdata_ext_2, ea, pay);
                end
            end else begin
                if (wen_ext !== 1'b1 || wen_ext_2 !== 1'b0 || addr_ext !== ea || wdata_ext !== pay[31:0]) begin
                    n_bad++;
                    $display("FAIL load_i_write k=%0d got wen=%b/%b addr=%h data=%h expected wen=1/0 addr=%h data=%h",
                             k, wen_ext, wen_ext_2, addr_ext, wdata_ext, ea, pay[31:0]);
                end
            end
            n_cmp++;
            if (err !== m_err || busy !== (k != n - 1) || cpu_enable !== 1'b0 || done !== m_done) begin
                n_bad++;
                $display("FAIL load_flags k=%0d got err=%b busy=%b en=%b done=%b expected err=%b busy=%b en=0 done=%b",
                         k, err, busy, cpu_enable, done, m_err, k != n - 1, m_done);
            end
        end
        drive(1'b0, 64'd0);
        n_cmp++;
        if (wen_ext !== 1'b0 || wen_ext_2 !== 1'b0 || busy !== 1'b0 || cycle_count !== CW'(m_cnt)) begin
            n_bad++;
            $display("FAIL load_after wen=%b/%b busy=%b cnt=%0d expected 0/0 busy=0 cnt=%0d",
                     wen_ext, wen_ext_2, busy, cycle_count, m_cnt);
        end
    endtask

    task automatic do_run(input int budget, input int stop_at, input int junk_at);
        logic [63:0] d;
        bit exited;
        exited = 1'b0;
        drive(1'b1, {2'b10, 30'd0, budget[31:0]});
        m_done = 1'b0;
        n_cmp++;
        if (cpu_enable !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || cycle_count !== '0) begin
            n_bad++;
            $display("FAIL run_start en=%b busy=%b done=%b cnt=%0d expected 1 1 0 0", cpu_enable, busy, done, cycle_count);
        end
        for (int i = 1; i <= 2000 && !exited; i++) begin
            d = {$urandom, $urandom};
            if (i == stop_at) begin
                d[63:62] = 2'b11;
                drive(1'b1, d);
            end else if (i == junk_at) begin
                d[63:62] = 2'(d[63:62] & 2'b10);
                drive(1'b1, d);
                m_err = 1'b1;
            end else begin
                drive(1'b0, d);
            end
            exited = (budget != 0 && i >= budget) || i == stop_at;
            n_cmp++;
            if (cycle_count !== CW'(i) || cpu_enable !== !exited || done !== exited || busy !== !exited ||
                err !== m_err || wen_ext !== 1'b0 || wen_ext_2 !== 1'b0) begin
                n_bad++;
                $display("FAIL run_cycle i=%0d got cnt=%0d en=%b done=%b busy=%b err=%b wen=%b/%b expected cnt=%0d en=%b done=%b err=%b wen=0/0",
                         i, cycle_count, cpu_enable, done, busy, err, wen_ext, wen_ext_2, i, !exited, exited, m_err);
            end
            if (exited) begin
                m_done = 1'b1;
                m_cnt  = i;
            end
        end
        if (!exited) begin
            n_bad++;
            $display("FAIL run_timeout budget=%0d stop_at=%0d run never ended in model", budget, stop_at);
        end
        drive(1'b0, 64'd0);
        n_cmp++;
        if (cpu_enable !== 1'b0 || cycle_count !== CW'(m_cnt) || done !== 1'b1) begin
            n_bad++;
            $display("FAIL run_hold en=%b cnt=%0d done=%b expected 0 %0d 1", cpu_enable, cycle_count, done, m_cnt);
        end
    endtask

    task automatic test_reset;
        arst = 1'b1; s_valid = 1'b0; s_data = '0;
        #12;
        n_cmp++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_enable !== 1'b0 ||
            wen_ext !== 1'b0 || wen_ext_2 !== 1'b0 || addr_ext !== '0 || cycle_count !== '0) begin
            n_bad++;
            $display("FAIL reset rdy=%b busy=%b done=%b err=%b en=%b wen=%b/%b", s_ready, busy, done, err, cpu_enable, wen_ext, wen_ext_2);
        end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_load_i_basic;  do_load(1'b0, 4, 3, 0);  endtask
    task automatic test_load_d_gaps;   do_load(1'b1, 2, 2, 3);  endtask
    task automatic test_run_budget;    do_run(5, 0, 0);         endtask
    task automatic test_run_stop;      do_run(0, 100, 0);       endtask
    task automatic test_stop_at_expiry; do_run(7, 7, 0);        endtask
    task automatic test_wrap;          do_load(1'b0, 510, 4, 1); endtask
    task automatic test_load_zero;     do_load(1'b1, 9, 0, 0);  endtask
    task automatic test_run_junk;      do_run(0, 30, 10);       endtask

    task automatic test_stop_idle;
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[63:62] = 2'b11;
        drive(1'b1, d);
        n_cmp++;
        if (busy !== 1'b0 || cpu_enable !== 1'b0 || done !== m_done || err !== m_err || cycle_count !== CW'(m_cnt)) begin
            n_bad++;
            $display("FAIL stop_idle busy=%b en=%b done=%b err=%b expected 0 0 %b %b", busy, cpu_enable, done, err, m_done, m_err);
        end
    endtask

    task automatic test_reset_mid_load;
        drive(1'b1, {2'b01, 14'd0, 16'd0, 16'd0, 16'd3});
        drive(1'b1, {$urandom, $urandom});
        n_cmp++;
        if (wen_ext_2 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_load_first_write wen_ext_2=%b expected 1", wen_ext_2);
        end
        #2 arst = 1'b1;
        #1;
        n_cmp++;
        if (wen_ext_2 !== 1'b0 || addr_ext_2 !== '0 || wdata_ext_2 !== '0 || busy !== 1'b0 ||
            err !== 1'b0 || done !== 1'b0 || cycle_count !== '0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset wen2=%b addr2=%h busy=%b err=%b done=%b rdy=%b expected 0 0 0 0 0 1",
                     wen_ext_2, addr_ext_2, busy, err, done, s_ready);
        end
        m_err = 1'b0; m_done = 1'b0; m_cnt = 0;
        @(negedge clk);
        arst = 1'b0;
        do_load(1'b0, 7, 1, 0);
    endtask

    task automatic test_random;
        int op, base, n, b, st;
        for (int it = 0; it < 25; it++) begin
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                base = ($urandom_range(0, 1) == 1) ? $urandom_range(500, 1023) : $urandom_range(0, 65535);
                n = $urandom_range(0, 6);
                do_load(op[0], base, n, 2);
            end else if (op == 2) begin
                b  = $urandom_range(1, 15);
                st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
                do_run(b, st, 0);
            end else begin
                test_stop_idle();
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_i_basic();
        test_load_d_gaps();
        test_run_budget();
        test_run_stop();
        test_stop_at_expiry();
        test_wrap();
        test_load_zero();
        test_stop_idle();
        test_run_junk();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
